// File: rtl/cam_i2c_pkg.sv
// cam_i2c_pkg
//   Shared definitions for the camera SCCB/I2C write master.
//   - i2c_state_t : transaction state encoding (IDLE, START, BIT, ACK, STOP)
//   - QUARTERS    : clk400 cycles per SCL bit period
//   - NBYTES      : bytes per transaction (slave addr+W, reg_hi, reg_lo, data)
//   - TXN_CYCLES  : accept-to-ready latency of a fully acknowledged transaction
//   - WRITE_BIT   : R/W bit value appended to the 7-bit slave address
package cam_i2c_pkg;

  localparam int QUARTERS   = 4;
  localparam int NBYTES     = 4;
  localparam int SHIFT_W    = NBYTES * 8;
  // START + (8 data bits + 1 ack bit) per byte + STOP, each phase is QUARTERS cycles
  localparam int TXN_CYCLES = QUARTERS + NBYTES * 9 * QUARTERS + QUARTERS;

  localparam logic WRITE_BIT = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP
  } i2c_state_t;

endpackage

// File: rtl/cam_i2c_phase_gen.sv
// cam_i2c_phase_gen
//   Quarter-phase counter that slices every bus phase into QUARTERS clk400 cycles.
//   Ports:
//     clk400       in  system clock
//     reset        in  synchronous, active-high reset
//     enable       in  advance the quarter counter this cycle
//     clear        in  synchronous clear to quarter 0 (wins over enable)
//     q0..q3       out one-hot strobes of the current quarter
//     last_quarter out high in the final quarter of an enabled phase
module cam_i2c_phase_gen
  import cam_i2c_pkg::*;
(
  input  logic clk400,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic q0,
  output logic q1,
  output logic q2,
  output logic q3,
  output logic last_quarter
);

  localparam int QW = $clog2(QUARTERS);

  logic [QW-1:0] quarter;

  // The counter wraps naturally at QUARTERS, so each bus phase lasts exactly
  // QUARTERS cycles as long as enable stays high.
  always_ff @(posedge clk400) begin
    if (reset || clear) begin
      quarter <= '0;
    end else if (enable) begin
      quarter <= quarter + QW'(1);
    end
  end

  assign q0           = (quarter == QW'(0));
  assign q1           = (quarter == QW'(1));
  assign q2           = (quarter == QW'(2));
  assign q3           = (quarter == QW'(3));
  assign last_quarter = enable & q3;

endmodule

// File: rtl/cam_sccb_write_master.sv
// cam_sccb_write_master
//   Executes one SCCB/I2C register write per request:
//   START, slave address + W, 16-bit register address (MSB first), data, STOP.
//   Ports:
//     clk400      in    system clock (4 cycles per SCL period)
//     reset       in    synchronous, active-high reset; aborts without STOP
//     send_data   in    request strobe, accepted only while ready=1
//     slave_addr  in    [6:0] device address, bit 7 ignored
//     register_in in    16-bit register address
//     datain      in    register data
//     ackn        in    1 = ignore NACKs, 0 = abort on NACK
//     ready       out   1 = idle and able to accept a request
//     nack        out   sticky, last transaction aborted on NACK
//     scl         inout open-drain clock, drives 0 or z
//     sda         inout open-drain data, drives 0 or z
module cam_sccb_write_master
  import cam_i2c_pkg::*;
(
  input  logic        clk400,
  input  logic        reset,
  input  logic        send_data,
  input  logic [7:0]  slave_addr,
  input  logic [15:0] register_in,
  input  logic [7:0]  datain,
  input  logic        ackn,
  output logic        ready,
  output logic        nack,
  inout  wire         scl,
  inout  wire         sda
);

  i2c_state_t state, state_nxt;

  logic [SHIFT_W-1:0] shift_q, shift_nxt;
  logic [2:0]         bit_cnt, bit_cnt_nxt;
  logic [1:0]         byte_cnt, byte_cnt_nxt;
  logic               ack_bit_q, ack_bit_nxt;
  logic               nack_q, nack_nxt;
  logic               ready_q, ready_nxt;
  logic               scl_drv_q, scl_drv_nxt;
  logic               sda_drv_q, sda_drv_nxt;

  logic q0, q1, q2, q3, last_quarter;
  logic [1:0] nq;

  // Bit 7 of the slave address carries no meaning on the bus.
  logic addr_msb_unused;
  assign addr_msb_unused = slave_addr[7];

  cam_i2c_phase_gen u_phase (
    .clk400       (clk400),
    .reset        (reset),
    .enable       (state != IDLE),
    .clear        (state == IDLE),
    .q0           (q0),
    .q1           (q1),
    .q2           (q2),
    .q3           (q3),
    .last_quarter (last_quarter)
  );

  // Quarter that the next cycle will be in. A phase change only ever happens
  // out of q3 or out of IDLE, so a new phase always starts at quarter 0.
  assign nq = (state == IDLE || q3) ? 2'd0 :
              q0                    ? 2'd1 :
              q1                    ? 2'd2 : 2'd3;

  // State register. The pin drivers and ready are registered here from
  // values decoded against the upcoming state, so they line up with it.
  always_ff @(posedge clk400) begin
    if (reset) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      ack_bit_q <= 1'b0;
      nack_q    <= 1'b0;
      ready_q   <= 1'b1;
      scl_drv_q <= 1'b0;
      sda_drv_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_q   <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      ack_bit_q <= ack_bit_nxt;
      nack_q    <= nack_nxt;
      ready_q   <= ready_nxt;
      scl_drv_q <= scl_drv_nxt;
      sda_drv_q <= sda_drv_nxt;
    end
  end

  // Next-state logic. The shift word moves one bit at the end of every data
  // bit, so the next bit is always at the MSB when its q0 begins.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_q;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    ack_bit_nxt  = ack_bit_q;
    nack_nxt     = nack_q;
    unique case (state)
      IDLE: begin
        if (send_data && ready_q) begin
          state_nxt    = START;
          shift_nxt    = {slave_addr[6:0], WRITE_BIT, register_in, datain};
          bit_cnt_nxt  = '0;
          byte_cnt_nxt = '0;
          nack_nxt     = 1'b0;
        end
      end
      START: begin
        if (last_quarter) state_nxt = BIT;
      end
      BIT: begin
        if (last_quarter) begin
          shift_nxt   = {shift_q[SHIFT_W-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = ACK;
        end
      end
      ACK: begin
        // SDA is sampled at the end of q2, while SCL is still high.
        if (q2) ack_bit_nxt = sda;
        if (last_quarter) begin
          if (ack_bit_q && !ackn) begin
            nack_nxt  = 1'b1;
            state_nxt = STOP;
          end else if (byte_cnt == 2'(NBYTES - 1)) begin
            state_nxt = STOP;
          end else begin
            byte_cnt_nxt = byte_cnt + 2'd1;
            state_nxt    = BIT;
          end
        end
      end
      STOP: begin
        if (last_quarter) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode for the upcoming (state, quarter). A drive value of 1
  // pulls the line low; 0 releases it to the pull-up.
  always_comb begin
    scl_drv_nxt = 1'b0;
    sda_drv_nxt = 1'b0;
    ready_nxt   = (state_nxt == IDLE);
    case (state_nxt)
      START: begin
        sda_drv_nxt = (nq != 2'd0);
        scl_drv_nxt = (nq == 2'd3);
      end
      BIT: begin
        sda_drv_nxt = ~shift_nxt[SHIFT_W-1];
        scl_drv_nxt = (nq == 2'd0) || (nq == 2'd3);
      end
      ACK: begin
        scl_drv_nxt = (nq == 2'd0) || (nq == 2'd3);
      end
      STOP: begin
        scl_drv_nxt = (nq == 2'd0);
        sda_drv_nxt = (nq == 2'd0) || (nq == 2'd1);
      end
      default: ;
    endcase
  end

  assign ready = ready_q;
  assign nack  = nack_q;
  assign scl   = scl_drv_q ? 1'b0 : 1'bz;
  assign sda   = sda_drv_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_cam_sccb_write_master.sv
// tb_cam_sccb_write_master
//   Directed bench for cam_sccb_write_master: a bus monitor decodes bytes and
//   acks from scl/sda, an optional slave model acknowledges every byte, and a
//   protocol watcher flags SDA changes during SCL high and bad SCL pulse widths.
module tb_cam_sccb_write_master;
  import cam_i2c_pkg::*;

  logic        clk400 = 1'b0;
  logic        reset;
  logic        send_data;
  logic [7:0]  slave_addr;
  logic [15:0] register_in;
  logic [7:0]  datain;
  logic        ackn;
  logic        ready;
  logic        nack;
  wire         scl_b;
  wire         sda_b;

  logic slave_low;
  logic slave_present;

  pullup (scl_b);
  pullup (sda_b);
  assign sda_b = slave_low ? 1'b0 : 1'bz;

  always #5 clk400 = ~clk400;

  cam_sccb_write_master dut (
    .clk400      (clk400),
    .reset       (reset),
    .send_data   (send_data),
    .slave_addr  (slave_addr),
    .register_in (register_in),
    .datain      (datain),
    .ackn        (ackn),
    .ready       (ready),
    .nack        (nack),
    .scl         (scl_b),
    .sda         (sda_b)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] regaddr;
    logic [7:0]  data;
    logic        ackn;
    logic        slave;
    int          exp_cycles;
    logic        exp_nack;
    int          exp_nbytes;
    logic [31:0] exp_frame;
  } vec_t;

  vec_t vecs[4];

  int vec_cnt     = 0;
  int miscompares = 0;

  // bus monitor state
  logic [7:0] byte_q[$];
  logic       ack_q[$];
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  int         proto_err = 0;
  logic       proto_en  = 1'b1;
  int         bit_idx   = 0;
  logic [7:0] cur_byte  = 8'h00;
  logic       p_scl = 1'b1, p_sda = 1'b1, mon_valid = 1'b0;
  int         lvl_cnt = 0;
  logic       hi_ok = 1'b0, lo_ok = 1'b0;

  // Bus monitor, slave model and protocol watcher, sampled mid-cycle.
  initial begin : monitor
    forever begin
      @(negedge clk400);
      if (mon_valid) begin
        if (sda_b != p_sda) begin
          if (scl_b && p_scl) begin
            if (!sda_b) begin
              start_cnt++;
              bit_idx   = 0;
              hi_ok     = 1'b0;
              lo_ok     = 1'b0;
              slave_low = 1'b0;
            end else begin
              stop_cnt++;
            end
          end else if (scl_b != p_scl) begin
            if (proto_en) proto_err++;
          end
        end
        if (scl_b && !p_scl) begin
          if (lo_ok && lvl_cnt != 2 && proto_en) proto_err++;
          hi_ok   = 1'b1;
          lvl_cnt = 1;
          if (bit_idx < 8) begin
            cur_byte = {cur_byte[6:0], sda_b};
            if (bit_idx == 7) byte_q.push_back(cur_byte);
            bit_idx++;
          end else begin
            ack_q.push_back(sda_b);
            bit_idx = 0;
          end
        end else if (!scl_b && p_scl) begin
          if (hi_ok && lvl_cnt != 2 && proto_en) proto_err++;
          lo_ok   = 1'b1;
          lvl_cnt = 1;
          if (bit_idx == 8)      slave_low = slave_present;
          else if (bit_idx == 0) slave_low = 1'b0;
        end else begin
          lvl_cnt++;
        end
      end
      p_scl     = scl_b;
      p_sda     = sda_b;
      mon_valid = 1'b1;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one request, optionally pulses send_data again while busy, and
  // returns the number of clk400 edges from the accepting edge until ready.
  task automatic applyStimulus(input vec_t v, input int busy_pulse_at, output int cycles);
    byte_q.delete();
    ack_q.delete();
    slave_present = v.slave;
    ackn          = v.ackn;
    slave_addr    = v.addr;
    register_in   = v.regaddr;
    datain        = v.data;
    checkOutput("ready_before_accept", {31'd0, ready}, 32'd1);
    send_data = 1'b1;
    @(posedge clk400);
    #1;
    send_data = 1'b0;
    checkOutput("ready_after_accept", {31'd0, ready}, 32'd0);
    checkOutput("nack_cleared_on_accept", {31'd0, nack}, 32'd0);
    cycles = 0;
    while (!ready && cycles < 400) begin
      if (busy_pulse_at != 0 && cycles == busy_pulse_at) begin
        slave_addr  = 8'h7F;
        register_in = 16'hFFFF;
        datain      = 8'h00;
        send_data   = 1'b1;
      end
      @(posedge clk400);
      #1;
      send_data = 1'b0;
      cycles++;
    end
  endtask

  task automatic checkFrame(input string tag, input vec_t v, input int cycles,
                            input int starts0, input int stops0);
    logic [31:0] act;
    checkOutput({tag, "_cycles"}, cycles, v.exp_cycles);
    checkOutput({tag, "_nack"}, {31'd0, nack}, {31'd0, v.exp_nack});
    checkOutput({tag, "_nbytes"}, byte_q.size(), v.exp_nbytes);
    checkOutput({tag, "_nacks_seen"}, ack_q.size(), v.exp_nbytes);
    checkOutput({tag, "_starts"}, start_cnt - starts0, 1);
    checkOutput({tag, "_stops"}, stop_cnt - stops0, 1);
    for (int i = 0; i < v.exp_nbytes; i++) begin
      act = (i < byte_q.size()) ? {24'd0, byte_q[i]} : 32'h100;
      checkOutput($sformatf("%s_byte%0d", tag, i), act, {24'd0, v.exp_frame[31-8*i -: 8]});
      act = (i < ack_q.size()) ? {31'd0, ack_q[i]} : 32'h100;
      checkOutput($sformatf("%s_ack%0d", tag, i), act, {31'd0, ~v.slave});
    end
  endtask

  initial begin : stimulus
    int   cycles;
    int   s0, t0, perr0;
    vec_t v;

    vecs[0] = '{8'h10, 16'h0100, 8'h01, 1'b0, 1'b1, 152, 1'b0, 4, 32'h2001_0001};
    vecs[1] = '{8'h10, 16'h0114, 8'hAA, 1'b0, 1'b0,  44, 1'b1, 1, 32'h2000_0000};
    vecs[2] = '{8'h10, 16'h0114, 8'hAA, 1'b1, 1'b0, 152, 1'b0, 4, 32'h2001_14AA};
    vecs[3] = '{8'hBC, 16'hA55A, 8'hFF, 1'b0, 1'b1, 152, 1'b0, 4, 32'h78A5_5AFF};

    reset         = 1'b1;
    send_data     = 1'b0;
    slave_addr    = 8'h00;
    register_in   = 16'h0000;
    datain        = 8'h00;
    ackn          = 1'b0;
    slave_low     = 1'b0;
    slave_present = 1'b0;
    repeat (3) @(posedge clk400);
    #1;
    reset = 1'b0;
    @(posedge clk400);
    #1;
    checkOutput("reset_ready", {31'd0, ready}, 32'd1);
    checkOutput("reset_nack", {31'd0, nack}, 32'd0);
    checkOutput("reset_scl", {31'd0, scl_b}, 32'd1);
    checkOutput("reset_sda", {31'd0, sda_b}, 32'd1);

    perr0 = proto_err;
    for (int i = 0; i < 4; i++) begin
      s0 = start_cnt;
      t0 = stop_cnt;
      applyStimulus(vecs[i], 0, cycles);
      checkFrame($sformatf("vec%0d", i), vecs[i], cycles, s0, t0);
    end
    checkOutput("table_protocol", proto_err - perr0, 0);

    // Request while busy is dropped; the follow-up issued as soon as ready
    // rises must produce its own clean frame.
    v = '{8'h21, 16'h1234, 8'h56, 1'b0, 1'b1, 152, 1'b0, 4, 32'h4212_3456};
    s0 = start_cnt;
    t0 = stop_cnt;
    applyStimulus(v, 50, cycles);
    checkFrame("busy", v, cycles, s0, t0);
    v = '{8'h3C, 16'h300A, 8'h0F, 1'b0, 1'b1, 152, 1'b0, 4, 32'h7830_0A0F};
    s0 = start_cnt;
    t0 = stop_cnt;
    applyStimulus(v, 0, cycles);
    checkFrame("after_busy", v, cycles, s0, t0);

    // Reset in the middle of a frame releases the bus on the next edge.
    proto_en      = 1'b0;
    slave_present = 1'b1;
    slave_addr    = 8'h10;
    register_in   = 16'h0100;
    datain        = 8'h01;
    ackn          = 1'b0;
    send_data     = 1'b1;
    @(posedge clk400);
    #1;
    send_data = 1'b0;
    repeat (69) @(posedge clk400);
    #1;
    reset = 1'b1;
    @(posedge clk400);
    #1;
    slave_low = 1'b0;
    checkOutput("midreset_scl", {31'd0, scl_b}, 32'd1);
    checkOutput("midreset_sda", {31'd0, sda_b}, 32'd1);
    checkOutput("midreset_ready", {31'd0, ready}, 32'd1);
    checkOutput("midreset_nack", {31'd0, nack}, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk400);
    #1;
    proto_en = 1'b1;
    s0 = start_cnt;
    t0 = stop_cnt;
    applyStimulus(vecs[0], 0, cycles);
    checkFrame("post_reset", vecs[0], cycles, s0, t0);

    // Ten back-to-back table writes under the protocol watcher.
    perr0 = proto_err;
    for (int i = 0; i < 10; i++) begin
      v.addr       = 8'h10 + 8'(i);
      v.regaddr    = 16'h3000 + 16'(i * 16'h0101);
      v.data       = 8'h5A ^ 8'(i);
      v.ackn       = 1'b0;
      v.slave      = 1'b1;
      v.exp_cycles = TXN_CYCLES;
      v.exp_nack   = 1'b0;
      v.exp_nbytes = NBYTES;
      v.exp_frame  = {v.addr[6:0], 1'b0, v.regaddr, v.data};
      s0 = start_cnt;
      t0 = stop_cnt;
      applyStimulus(v, 0, cycles);
      checkFrame($sformatf("b2b%0d", i), v, cycles, s0, t0);
    end
    checkOutput("b2b_protocol", proto_err - perr0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/cam_sccb_write_master.md
Name: cam_sccb_write_master

Overview:
- Downstream stage of the camera init sequencer.
- Executes one I2C/SCCB register-write transaction per request: START, 7-bit slave address + W, 16-bit register address (MSB first), 8-bit data, STOP.
- Drives the sensor's open-drain scl/sda pins. Raises ready on completion so the sequencer can issue the next table entry on ready's rising edge.

Parameters:
- QUARTERS, 4, clk400 cycles per SCL bit period (fixed quarter-phase scheme; 400 kHz clock gives 100 kHz SCL)
- NBYTES, 4, bytes per transaction (addr, reg_hi, reg_lo, data)

Ports:
- clk400  in  1  system clock for this block
- reset  in  1  synchronous, active-high reset
- send_data  in  1  request strobe; accepted only when ready=1
- slave_addr  in  8  bits[6:0] = 7-bit device address; bit7 ignored
- register_in  in  16  register address
- datain  in  8  register data
- ackn  in  1  1 = ignore NACKs; 0 = abort on NACK
- ready  out  1  1 = idle and able to accept
- nack  out  1  sticky; last transaction aborted on NACK
- scl  inout  1  open-drain: drives 0 or z
- sda  inout  1  open-drain: drives 0 or z

Behaviour:
- Reset (synchronous): state IDLE, ready=1, nack=0, scl=z, sda=z, counters 0. Reset mid-transaction aborts immediately and releases both lines. No STOP is generated.
- Accept: rising clk400 edge with send_data=1 and ready=1.
  - Latch shift word {slave_addr[6:0],1'b0, register_in[15:8], register_in[7:0], datain}.
  - Clear nack.
  - ready=0 from the next cycle.
  - send_data while ready=0 is ignored; it is not queued.
- States: IDLE -> START -> BIT -> ACK -> (BIT | STOP) -> IDLE.
- START (4 cycles), starting from both lines released:
  - q0: hold released.
  - q1: sda=0 while scl is high.
  - q2: hold.
  - q3: scl=0.
- BIT (4 cycles per data bit):
  - q0: scl=0, sda=current MSB (0 -> drive 0, 1 -> z).
  - q1: release scl.
  - q2: hold.
  - q3: scl=0; shift.
  - 8 bits per byte.
- ACK (4 cycles):
  - sda released in q0–q3.
  - scl released in q1–q2.
  - sda sampled in q2; sampled 0 = ACK.
  - Sampled 1 with ackn=0: nack<=1, go to STOP.
  - Sampled 1 with ackn=1: continue.
  - After the 4th ACK, go to STOP.
- STOP (4 cycles):
  - q0: scl=0, sda=0.
  - q1: release scl.
  - q2: release sda (SDA rises while SCL is high).
  - q3: hold released; ready<=1, state IDLE.
- Latency:
  - Full transaction: ready returns high exactly 4 + 36·4 + 4 = 152 cycles after the accepting edge.
  - NACK on byte k (1..4): ready returns 4 + 36k + 4 cycles after the accepting edge.
- A new request accepted in the same cycle ready becomes 1 starts START from released lines. Bus idle time between transactions is at least one cycle.
- No clock stretching: scl is never sampled.
- No read transactions.
- Counters:
  - 2-bit quarter counter.
  - 3-bit bit counter (wraps 7 -> 0 into ACK).
  - 2-bit byte counter (terminal 3).
- Outputs are registered; no combinational path from inputs to scl/sda/ready.

Decomposition:
- Package cam_i2c_pkg holds:
  - state enum (IDLE, START, BIT, ACK, STOP)
  - QUARTERS, NBYTES, TXN_CYCLES=152
  - write-bit constant (0)
- One natural sub-module: cam_i2c_phase_gen.
  - Quarter-phase counter with enable and synchronous clear.
  - Outputs q0..q3 strobes and last_quarter.
  - The main FSM consumes these strobes.

Test Plan:
- Write 0x0100=0x01 to addr 0x10, slave model ACKs all bytes:
  - decoded bus bytes 0x20, 0x01, 0x00, 0x01
  - ready low 152 cycles, nack=0
- No slave (pull-up only), ackn=0, send 0x10/0x0114/0xAA:
  - first ACK samples 1
  - STOP follows, nack=1
  - ready returns 44 cycles after accept
- Same as previous with ackn=1:
  - full 4-byte frame emitted, nack=0, ready returns after 152 cycles
- send_data pulsed at cycle 50 of an active transaction:
  - ignored, bus frame unchanged
  - a second request issued on ready's rising edge starts a clean START
- Reset asserted at cycle 70 of a transaction:
  - next cycle scl=z, sda=z, ready=1, nack=0
  - subsequent request completes normally
- Protocol checker over 10 back-to-back table writes:
  - sda changes only while scl=0, except START/STOP edges
  - SCL high and low times are each 2 cycles
